// File: rtl/reg_debug_access.sv
// Debug-side register file initiator: halts the core, performs one read or write, returns a response.
// Optional write read-back check enabled by defining REG_DEBUG_READBACK_EN.
module reg_debug_access #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 5,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_halt_req,
  input  logic                  i_halted,
  output logic [ADDR_WIDTH-1:0] o_rf_read_addr,
  input  logic [DATA_WIDTH-1:0] i_rf_read_data,
  output logic                  o_rf_write_en,
  output logic [ADDR_WIDTH-1:0] o_rf_write_addr,
  output logic [DATA_WIDTH-1:0] o_rf_write_data
);

  // state     | meaning
  // IDLE      | ready for a command, core released
  // HALT_WAIT | halt requested, waiting for i_halted or timeout
  // ACCESS    | one-cycle register file read or write
  // VERIFY    | read back the just-written register (feature only)
  // RESP      | response held until accepted
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HALT_WAIT = 3'd1,
    ACCESS    = 3'd2,
`ifdef REG_DEBUG_READBACK_EN
    VERIFY    = 3'd3,
`endif
    RESP      = 3'd4
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(HALT_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  req_ready_q, req_ready_d;
  logic                  halt_req_q, halt_req_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] rf_read_addr_q, rf_read_addr_d;
  logic                  rf_write_en_q, rf_write_en_d;
  logic [ADDR_WIDTH-1:0] rf_write_addr_q, rf_write_addr_d;
  logic [DATA_WIDTH-1:0] rf_write_data_q, rf_write_data_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          wr_d    = i_req_write;
          addr_d  = i_req_addr;
          wdata_d = i_req_wdata;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = HALT_WAIT;
        end
      end
      HALT_WAIT: begin
        if (i_halted) begin
          state_d = ACCESS;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ACCESS: begin
        rdata_d = wr_q ? '0 : i_rf_read_data;
        err_d   = 1'b0;
`ifdef REG_DEBUG_READBACK_EN
        state_d = wr_q ? VERIFY : RESP;
`else
        state_d = RESP;
`endif
      end
`ifdef REG_DEBUG_READBACK_EN
      VERIFY: begin
        // x0 reads back as 0, so a nonzero write to it reports a mismatch
        if (i_rf_read_data != wdata_q) begin
          rdata_d = i_rf_read_data;
          err_d   = 1'b1;
        end else begin
          rdata_d = '0;
          err_d   = 1'b0;
        end
        state_d = RESP;
      end
`endif
      RESP: begin
        if (i_rsp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs follow the next state so they line up with state_q after the edge
    req_ready_d     = (state_d == IDLE);
    halt_req_d      = (state_d != IDLE);
    rsp_valid_d     = (state_d == RESP);
    rf_read_addr_d  = (state_d != IDLE) ? addr_d : '0;
    rf_write_en_d   = (state_d == ACCESS) && wr_d;
    rf_write_addr_d = rf_write_en_d ? addr_d : '0;
    rf_write_data_d = rf_write_en_d ? wdata_d : '0;
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      wr_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      rdata_q         <= '0;
      err_q           <= 1'b0;
      req_ready_q     <= 1'b1;
      halt_req_q      <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rf_read_addr_q  <= '0;
      rf_write_en_q   <= 1'b0;
      rf_write_addr_q <= '0;
      rf_write_data_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      wr_q            <= wr_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      rdata_q         <= rdata_d;
      err_q           <= err_d;
      req_ready_q     <= req_ready_d;
      halt_req_q      <= halt_req_d;
      rsp_valid_q     <= rsp_valid_d;
      rf_read_addr_q  <= rf_read_addr_d;
      rf_write_en_q   <= rf_write_en_d;
      rf_write_addr_q <= rf_write_addr_d;
      rf_write_data_q <= rf_write_data_d;
    end
  end

  assign o_req_ready     = req_ready_q;
  assign o_halt_req      = halt_req_q;
  assign o_rsp_valid     = rsp_valid_q;
  assign o_rsp_rdata     = rdata_q;
  assign o_rsp_err       = err_q;
  assign o_rf_read_addr  = rf_read_addr_q;
  assign o_rf_write_en   = rf_write_en_q;
  assign o_rf_write_addr = rf_write_addr_q;
  assign o_rf_write_data = rf_write_data_q;

endmodule

// File: doc/reg_debug_access.md
Name: reg_debug_access

Overview:
- Debug-side initiator for the register file: accepts single read/write requests on a valid/ready command channel and halts the core.
- Performs the access on the register file's read port and write port 3, then returns data and status on a valid/ready response channel.
- Sits between the external debug transport and the register file port muxes.
- Gives simulation/bring-up a way to load and inspect x1..x31 (e.g. a0) without executing instructions.

Parameters:
- DATA_WIDTH, 64, register width.
- ADDR_WIDTH, 5, register index width.
- HALT_TIMEOUT, 255, max cycles to wait for i_halted before aborting; must be 1..2^16-1.

Ports:
- clk  input  1  clock, all state on rising edge.
- arst  input  1  reset, synchronous, active-high.
- i_req_valid  input  1  command valid.
- o_req_ready  output  1  command ready.
- i_req_write  input  1  1 = write, 0 = read.
- i_req_addr  input  ADDR_WIDTH  target register.
- i_req_wdata  input  DATA_WIDTH  write data.
- o_rsp_valid  output  1  response valid.
- i_rsp_ready  input  1  response accepted.
- o_rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors.
- o_rsp_err  output  1  1 = timeout (or read-back mismatch, see feature).
- o_halt_req  output  1  request core quiescence.
- i_halted  input  1  core is quiescent; register file ports free.
- o_rf_read_addr  output  ADDR_WIDTH  to register file read address 1 mux.
- i_rf_read_data  input  DATA_WIDTH  register file read data 1 (combinational).
- o_rf_write_en  output  1  to write_en_3 mux.
- o_rf_write_addr  output  ADDR_WIDTH  to write address 3 mux.
- o_rf_write_data  output  DATA_WIDTH  to write data 3 mux.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, arst).
- FSM states: IDLE, HALT_WAIT, ACCESS, VERIFY (feature only), RESP.
- Reset:
  - State returns to IDLE.
  - All outputs 0 except o_req_ready, which is 1.
  - Timeout counter, latched command and response registers cleared.
  - Applies from any state; no o_rf_write_en pulse during or after reset.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid & o_req_ready: latch write/addr/wdata, clear counter, go to HALT_WAIT.
  - o_req_ready=0 in every other state; i_req_valid there is ignored, not queued.
- HALT_WAIT:
  - o_halt_req=1, which stays 1 through ACCESS/VERIFY/RESP and drops on the cycle the FSM re-enters IDLE.
  - If i_halted=1, go to ACCESS next cycle.
  - Otherwise increment the counter. When counter==HALT_TIMEOUT-1 and i_halted=0, go to RESP with err=1, rdata=0, and no register file activity.
- ACCESS (exactly one cycle):
  - o_rf_read_addr = latched addr in all non-IDLE states; 0 in IDLE.
  - Read: capture i_rf_read_data into the response register.
  - Write: o_rf_write_en=1 for this cycle only; o_rf_write_addr/o_rf_write_data = latched values (0 outside ACCESS).
  - Writes to x0 still pulse o_rf_write_en; the register file keeps x0 at 0.
  - Next state: RESP (or VERIFY for writes with the feature enabled).
- RESP:
  - o_rsp_valid=1 with stable rdata/err until i_rsp_ready=1; then go to IDLE.
  - Response fields clear on leaving RESP.
- Latency with i_halted already 1 and i_rsp_ready=1: accept at edge T0; HALT_WAIT T0–T1; ACCESS T1–T2; o_rsp_valid high T2–T3; back in IDLE at T3. The next command can be accepted at edge T4.
- i_halted falling during ACCESS/RESP is ignored; the access completes.

Optional Feature:
- Macro: REG_DEBUG_READBACK_EN.
- Defined:
  - Writes pass through VERIFY for one cycle with o_rf_read_addr = latched addr.
  - Compare i_rf_read_data with latched wdata; mismatch sets o_rsp_err=1 and o_rsp_rdata = value read back. On match, rdata=0 and err=0.
  - Write latency is +1 cycle.
- Not defined: no VERIFY state; write responses always carry err=0 and rdata=0 unless timed out.

Test Plan:
- Reset, then write addr 10 data 64'h1, i_halted=1 -> o_rf_write_en one cycle with addr 10/data 1; response err=0 three cycles after accept (four with feature).
- Read addr 10 with i_rf_read_data modelled from write -> o_rsp_rdata=64'h1, err=0; o_halt_req low the cycle after handshake.
- i_halted held 0, HALT_TIMEOUT=8 -> o_rsp_valid after 8 HALT_WAIT cycles with err=1, rdata=0; o_rf_write_en never asserted.
- i_rsp_ready low 5 cycles -> o_rsp_valid/rdata stable 5 cycles; i_req_valid pulses during this are not accepted (o_req_ready=0).
- With REG_DEBUG_READBACK_EN, write addr 0 data 64'hDEAD -> err=1, rdata=0; without the macro -> err=0.
- arst asserted during ACCESS of a write -> no write pulse after reset, state IDLE, o_req_ready=1, o_halt_req=0 on the next cycle.
